vram_arbiter: RTL and testbench
===============================

// Module: vram_arbiter
// PURPOSE
//  Shares the single-port 8 KB video RAM between the VGA fetch path and the 6502 CPU bus.
//  Video fetch has fixed priority and a fixed 2-cycle latency, so a character or pixel byte
//  fetched on hor_counter[3:0]==0 is stable well before the cycle-15 load.
//  The CPU gets the remaining slots through a req/ack handshake.
//  Sits between the vga block, the CPU address decoder and the VRAM instance.
// PARAMETERS
//  ADDR_W        13  VRAM address width (bytes = 2**ADDR_W)
//  STARVE_LIMIT  4   consecutive denied cycles after which a pending CPU request overrides video
// PORTS
//  clk        in   1       pixel clock, all logic on posedge
//  reset      in   1       asynchronous, active-high
//  vid_req    in   1       1-cycle fetch strobe from the vga block
//  vid_addr   in   ADDR_W  fetch address, valid with vid_req
//  vid_data   out  8       fetched byte, held until next fetch completes
//  vid_miss   out  1       sticky: a vid_req was dropped by the starvation override
//  cpu_req    in   1       CPU access request, held until cpu_ack
//  cpu_we     in   1       1=write, 0=read; stable while cpu_req
//  cpu_addr   in   ADDR_W  CPU address; stable while cpu_req
//  cpu_wdata  in   8       write data; stable while cpu_req
//  cpu_ack    out  1       1-cycle completion pulse
//  cpu_rdata  out  8       read data, valid in the cpu_ack cycle
//  ram_addr   out  ADDR_W  VRAM address (combinational from grant)
//  ram_we     out  1       VRAM write enable
//  ram_wdata  out  8       VRAM write data
//  ram_rdata  in   8       VRAM sync read data, 1 cycle after ram_addr
// BEHAVIOUR
//  Reset: vid_data=0, vid_miss=0, cpu_ack=0, cpu_rdata=0, ram_we=0, ram_addr=0, ram_wdata=0,
//   CPU FSM=C_IDLE, starve_cnt=0, vid pipeline flag=0. Reset mid-access aborts; no ack is issued.
//  Grant (combinational, per cycle):
//   - vid_req is granted, unless starve_cnt==STARVE_LIMIT.
//   - Otherwise a pending buffer drain is granted (WBUF only).
//   - Otherwise cpu_req is granted when the FSM is in C_IDLE.
//  Video: grant at N drives ram_addr=vid_addr; vid_data <= ram_rdata at edge ending N+1;
//   the new value is visible at N+2. Back-to-back vid_req is legal, one per cycle, pipelined.
//  CPU FSM: C_IDLE -> C_RD (read granted) -> C_ACK; C_IDLE -> C_ACK (write granted, ram_we=1).
//   C_ACK: cpu_ack=1 for one cycle; cpu_rdata was captured from ram_rdata at end of C_RD.
//   C_ACK -> C_IDLE unconditionally. cpu_req seen in the C_ACK cycle is ignored.
//   A new request is taken no earlier than the cycle after C_IDLE is re-entered.
//  starve_cnt: increments each cycle cpu_req is pending in C_IDLE but denied; saturates at
//   STARVE_LIMIT; clears on CPU grant.
//   At the limit: CPU wins, the concurrent vid_req is dropped (vid_data unchanged), vid_miss<=1.
//  Min CPU latency: write req->ack 2 cycles; read req->ack 3 cycles.
//  Address width: no wrap logic; addresses pass through unmodified.
// CONFIGURATION
//  VRAM_WBUF_EN defined: 1-entry posted write buffer (addr, data, valid).
//   - CPU write in C_IDLE with buffer empty: captured with no RAM slot needed; cpu_ack next cycle.
//   - Write with buffer full: waits until the buffer drains.
//   - Drain happens in any cycle with no video grant; the valid flag clears on the drain edge.
//   - CPU read whose address equals the buffered address: data forwarded from the buffer,
//     no RAM access, ack at 2 cycles.
//   - Non-matching read: waits for the drain first, preserving order.
//   - The starvation override also applies to the drain.
//  VRAM_WBUF_EN undefined: writes go straight to RAM as described above; no buffer registers.
// STRUCTURE
//  Shared header vga/vram_defs.vh holds:
//   - CPU FSM state localparams (C_IDLE, C_RD, C_ACK);
//   - VID_LATENCY=2;
//   - VRAM_ADDR_W=13.
//  Sub-module vram_wbuf (buffer, hit compare, drain request) is instantiated only under VRAM_WBUF_EN.
//  Grant mux and FSM stay in vram_arbiter.
// TESTING
//  1 RAM model preloaded with mem[0x0123]=0x5A; vid_req @0x0123, no CPU -> vid_data==0x5A
//    exactly 2 cycles later; ram_we never high.
//  2 cpu write 0x1FFF<=0xC3 while idle -> ram_we at grant cycle, ack after 2 cycles;
//    then cpu read 0x1FFF -> ack after 3 cycles, cpu_rdata==0xC3.
//  3 cpu_req read and vid_req in same cycle -> video granted, CPU granted next cycle;
//    ack delayed 1 cycle; vid_data correct.
//  4 vid_req held high 6 cycles with cpu read pending, STARVE_LIMIT=4 -> CPU granted in
//    5th cycle, vid_miss=1 and stays 1; vid_data skips that fetch.
//  5 assert reset during C_RD -> all outputs at reset values immediately;
//    no cpu_ack after release; next read completes normally.
//  6 (WBUF) write 0x0040<=0x11 then read 0x0040 while vid_req every cycle ->
//    write acked after 1 cycle, read acked with 0x11 forwarded; drain occurs after video stops.

Source files
------------

// File: rtl/vram_arbiter_pkg.sv
// vram_arbiter_pkg: shared definitions for the VRAM arbiter slice.
//   VRAM_ADDR_W  default VRAM address width (8 KB video RAM)
//   VID_LATENCY  cycles from video grant to vid_data update (grant N, visible N+2)
//   cpu_state_t  CPU access FSM states (C_IDLE, C_RD, C_ACK)
package vram_arbiter_pkg;

  localparam int VRAM_ADDR_W = 13;
  localparam int VID_LATENCY = 2;

  typedef enum logic [1:0] {
    C_IDLE = 2'd0,
    C_RD   = 2'd1,
    C_ACK  = 2'd2
  } cpu_state_t;

endpackage

// File: rtl/vram_arbiter_if.sv
// vram_arbiter_if: bus bundle between the video fetch path, the CPU bus,
// the VRAM instance and the arbiter.
//   vid_req/vid_addr        -> 1-cycle fetch strobe + address
//   vid_data/vid_miss       <- fetched byte, sticky dropped-fetch flag
//   cpu_req/we/addr/wdata   -> CPU access request, held until cpu_ack
//   cpu_ack/cpu_rdata       <- 1-cycle completion pulse + read data
//   ram_addr/we/wdata       <- VRAM port (combinational from grant)
//   ram_rdata               -> VRAM sync read data, 1 cycle after ram_addr
//   dbg_state               <- CPU FSM state, for observation only
// Handshake: the CPU raises cpu_req with stable we/addr/wdata and keeps it
// high until it sees cpu_ack=1 on a rising edge; cpu_ack is a single-cycle
// pulse and cpu_rdata is valid only in that cycle. vid_req needs no
// acknowledge: a granted fetch always lands 2 cycles later, a dropped one
// sets vid_miss.
// modport slave is the arbiter side, modport master the environment side.
interface vram_arbiter_if #(
  parameter int ADDR_W = 13
);

  logic                       vid_req;
  logic [ADDR_W-1:0]          vid_addr;
  logic [7:0]                 vid_data;
  logic                       vid_miss;

  logic                       cpu_req;
  logic                       cpu_we;
  logic [ADDR_W-1:0]          cpu_addr;
  logic [7:0]                 cpu_wdata;
  logic                       cpu_ack;
  logic [7:0]                 cpu_rdata;

  logic [ADDR_W-1:0]          ram_addr;
  logic                       ram_we;
  logic [7:0]                 ram_wdata;
  logic [7:0]                 ram_rdata;

  vram_arbiter_pkg::cpu_state_t dbg_state;

  modport slave (
    input  vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
    output vid_data, vid_miss, cpu_ack, cpu_rdata, ram_addr, ram_we, ram_wdata,
    output dbg_state
  );

  modport master (
    output vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
    input  vid_data, vid_miss, cpu_ack, cpu_rdata, ram_addr, ram_we, ram_wdata,
    input  dbg_state
  );

endinterface

// File: rtl/vram_arbiter_wbuf.sv
// vram_arbiter_wbuf: 1-entry posted write buffer for the VRAM arbiter.
// Only present when VRAM_WBUF_EN is defined.
//   clk, reset    pixel clock, async active-high reset
//   capture       take cap_addr/cap_data into the (empty) entry
//   drain         the entry is being written to VRAM this cycle
//   lookup_addr   CPU read address to compare against the entry
//   drain_req     entry valid, wants a RAM slot
//   hit           entry valid and its address equals lookup_addr
//   buf_addr/data entry contents, used for the drain and for forwarding
`ifdef VRAM_WBUF_EN
module vram_arbiter_wbuf #(
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              capture,
  input  logic [ADDR_W-1:0] cap_addr,
  input  logic [7:0]        cap_data,
  input  logic              drain,
  input  logic [ADDR_W-1:0] lookup_addr,
  output logic              drain_req,
  output logic              hit,
  output logic [ADDR_W-1:0] buf_addr,
  output logic [7:0]        buf_data
);

  logic              valid_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        data_q;

  // capture is only ever requested while the entry is empty, and drain only
  // while it is full, so the two never collide.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else if (capture) begin
      valid_q <= 1'b1;
      addr_q  <= cap_addr;
      data_q  <= cap_data;
    end else if (drain) begin
      valid_q <= 1'b0;
    end
  end

  assign drain_req = valid_q;
  assign hit       = valid_q && (lookup_addr == addr_q);
  assign buf_addr  = addr_q;
  assign buf_data  = data_q;

endmodule
`endif

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares the single-port 8 KB VRAM between the VGA fetch path
// and the 6502 CPU bus.
//   clk    pixel clock, everything on posedge
//   reset  asynchronous, active-high; aborts an access in flight, no ack
//   bus    vram_arbiter_if.slave: video fetch, CPU req/ack, VRAM port, dbg_state
// Video has fixed priority and fixed 2-cycle latency. A CPU request that has
// been refused STARVE_LIMIT times in a row wins the next slot; a vid_req in
// that cycle is dropped and vid_miss is set (sticky until reset).
// Optional feature: define VRAM_WBUF_EN to add a 1-entry posted write buffer
// (writes ack without a RAM slot, same-address reads are forwarded, the
// buffer drains in any slot video does not use).
module vram_arbiter
  import vram_arbiter_pkg::*;
#(
  parameter int ADDR_W       = VRAM_ADDR_W,
  parameter int STARVE_LIMIT = 4
) (
  input logic           clk,
  input logic           reset,
  vram_arbiter_if.slave bus
);

  localparam int                CNT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STARVE_LIMIT);
  localparam int                VP_W    = VID_LATENCY - 1;

  cpu_state_t        state_q, state_d;
  logic [CNT_W-1:0]  starve_q;
  logic [VP_W-1:0]   vid_pipe_q;
  logic [7:0]        vid_data_q;
  logic              vid_miss_q;
  logic [7:0]        cpu_rdata_q;

  logic              cpu_pending;
  logic              starve_hit;
  logic              vid_gnt;
  logic              vid_drop;
  logic              cpu_rd_gnt;  // CPU read takes the RAM slot -> C_RD
  logic              cpu_wr_gnt;  // CPU write accepted -> C_ACK
  logic              cpu_fwd;     // CPU read served without RAM -> C_ACK
  logic              cpu_accept;

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [7:0]        ram_wdata;

  // ---------------------------------------------------------------- grant
  always_comb begin
    cpu_pending = bus.cpu_req && (state_q == C_IDLE);
    starve_hit  = cpu_pending && (starve_q == CNT_MAX);
    vid_gnt     = bus.vid_req && !starve_hit;
    vid_drop    = bus.vid_req && starve_hit;
  end

`ifdef VRAM_WBUF_EN
  logic              buf_valid;
  logic              buf_hit;
  logic              drain_gnt;
  logic [ADDR_W-1:0] buf_addr;
  logic [7:0]        buf_data;

  vram_arbiter_wbuf #(
    .ADDR_W (ADDR_W)
  ) u_wbuf (
    .clk         (clk),
    .reset       (reset),
    .capture     (cpu_wr_gnt),
    .cap_addr    (bus.cpu_addr),
    .cap_data    (bus.cpu_wdata),
    .drain       (drain_gnt),
    .lookup_addr (bus.cpu_addr),
    .drain_req   (buf_valid),
    .hit         (buf_hit),
    .buf_addr    (buf_addr),
    .buf_data    (buf_data)
  );

  // Writes and buffer-hit reads need no RAM slot, so they are accepted even
  // while video owns the port. Anything else must wait for the buffer to be
  // empty so the RAM sees accesses in program order. When the starvation
  // override removes video, the freed slot goes to the drain first if the
  // buffer is full; the CPU still sits at the limit and wins the next slot.
  always_comb begin
    drain_gnt  = buf_valid && !vid_gnt;
    cpu_wr_gnt = cpu_pending && bus.cpu_we && !buf_valid;
    cpu_fwd    = cpu_pending && !bus.cpu_we && buf_hit;
    cpu_rd_gnt = cpu_pending && !bus.cpu_we && !buf_valid && !vid_gnt;
    ram_addr   = '0;
    ram_we     = 1'b0;
    ram_wdata  = '0;
    if (vid_gnt) begin
      ram_addr = bus.vid_addr;
    end else if (drain_gnt) begin
      ram_addr  = buf_addr;
      ram_we    = 1'b1;
      ram_wdata = buf_data;
    end else if (cpu_rd_gnt) begin
      ram_addr = bus.cpu_addr;
    end
  end
`else
  always_comb begin
    cpu_rd_gnt = cpu_pending && !bus.cpu_we && !vid_gnt;
    cpu_wr_gnt = cpu_pending && bus.cpu_we && !vid_gnt;
    cpu_fwd    = 1'b0;
    ram_addr   = '0;
    ram_we     = 1'b0;
    ram_wdata  = '0;
    if (vid_gnt) begin
      ram_addr = bus.vid_addr;
    end else if (cpu_rd_gnt) begin
      ram_addr = bus.cpu_addr;
    end else if (cpu_wr_gnt) begin
      ram_addr  = bus.cpu_addr;
      ram_we    = 1'b1;
      ram_wdata = bus.cpu_wdata;
    end
  end
`endif

  assign cpu_accept = cpu_rd_gnt || cpu_wr_gnt || cpu_fwd;

  // ------------------------------------------------------------- CPU FSM
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      C_IDLE: begin
        if (cpu_rd_gnt) begin
          state_d = C_RD;
        end else if (cpu_wr_gnt || cpu_fwd) begin
          state_d = C_ACK;
        end
      end
      C_RD:    state_d = C_ACK;
      C_ACK:   state_d = C_IDLE;   // cpu_req in this cycle is not looked at
      default: state_d = C_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= C_IDLE;
      starve_q    <= '0;
      vid_pipe_q  <= '0;
      vid_data_q  <= '0;
      vid_miss_q  <= 1'b0;
      cpu_rdata_q <= '0;
    end else begin
      state_q <= state_d;

      // Counts refused cycles of a request waiting in C_IDLE; saturates so
      // the override stays active until the CPU is actually accepted.
      if (cpu_accept) begin
        starve_q <= '0;
      end else if (cpu_pending && (starve_q != CNT_MAX)) begin
        starve_q <= starve_q + CNT_W'(1);
      end

      // The flag marks that ram_rdata in this cycle belongs to a video fetch.
      vid_pipe_q <= VP_W'({vid_pipe_q, vid_gnt});
      if (vid_pipe_q[VP_W-1]) begin
        vid_data_q <= bus.ram_rdata;
      end

      if (vid_drop) begin
        vid_miss_q <= 1'b1;
      end

      if (state_q == C_RD) begin
        cpu_rdata_q <= bus.ram_rdata;
      end
`ifdef VRAM_WBUF_EN
      else if (cpu_fwd) begin
        cpu_rdata_q <= buf_data;
      end
`endif
    end
  end

  // ------------------------------------------------------------- outputs
  assign bus.vid_data  = vid_data_q;
  assign bus.vid_miss  = vid_miss_q;
  assign bus.cpu_ack   = (state_q == C_ACK);
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.ram_addr  = ram_addr;
  assign bus.ram_we    = ram_we;
  assign bus.ram_wdata = ram_wdata;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed self-checking bench for vram_arbiter.
// Contains a synchronous 8 KB RAM model with a bench-only load port; inputs
// are driven 1 time unit after posedge, outputs are sampled on negedge.
module tb_vram_arbiter;
  import vram_arbiter_pkg::*;

  logic clk = 1'b0;
  logic reset;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  mem [0:8191];
  logic        ld_en;
  logic [12:0] ld_addr;
  logic [7:0]  ld_data;

  vram_arbiter_if #(.ADDR_W(13)) bus ();

  vram_arbiter #(
    .ADDR_W       (13),
    .STARVE_LIMIT (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // ---------------------------------------------------- clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not reach its end within the time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------- RAM model
  always @(posedge clk) begin
    if (ld_en) begin
      mem[ld_addr] <= ld_data;
    end else if (bus.ram_we) begin
      mem[bus.ram_addr] <= bus.ram_wdata;
    end
    bus.ram_rdata <= mem[bus.ram_addr];
  end

  // ------------------------------------------------------ driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic load(input logic [12:0] a, input logic [7:0] d);
    ld_en   = 1'b1;
    ld_addr = a;
    ld_data = d;
    tick();
  endtask

  task automatic cpu_drive(input logic req, input logic we,
                           input logic [12:0] a, input logic [7:0] d);
    bus.cpu_req   = req;
    bus.cpu_we    = we;
    bus.cpu_addr  = a;
    bus.cpu_wdata = d;
  endtask

  // ------------------------------------------------------------ checker
  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------- sequence
  initial begin
    reset        = 1'b1;
    ld_en        = 1'b0;
    ld_addr      = '0;
    ld_data      = '0;
    bus.vid_req  = 1'b0;
    bus.vid_addr = '0;
    cpu_drive(1'b0, 1'b0, 13'h0000, 8'h00);

    // reset values
    repeat (2) @(posedge clk);
    mid();
    check("rst_vid_data",  32'(bus.vid_data),  32'h00);
    check("rst_vid_miss",  32'(bus.vid_miss),  32'h0);
    check("rst_cpu_ack",   32'(bus.cpu_ack),   32'h0);
    check("rst_cpu_rdata", 32'(bus.cpu_rdata), 32'h00);
    check("rst_ram_we",    32'(bus.ram_we),    32'h0);
    check("rst_ram_addr",  32'(bus.ram_addr),  32'h0000);
    check("rst_ram_wdata", 32'(bus.ram_wdata), 32'h00);
    check("rst_state",     32'(bus.dbg_state), 32'(C_IDLE));
    tick();
    reset = 1'b0;

    // preload: 0x0123=0x5A, 0x0100..0x0105 = 0x10..0x15
    load(13'h0123, 8'h5A);
    for (int i = 0; i < 6; i++) begin
      load(13'h0100 + 13'(i), 8'h10 + 8'(i));
    end
    ld_en = 1'b0;

    // 1: lone video fetch, data visible 2 cycles after the grant
    bus.vid_req  = 1'b1;
    bus.vid_addr = 13'h0123;
    mid();
    check("v1_ram_addr", 32'(bus.ram_addr), 32'h0123);
    check("v1_ram_we0",  32'(bus.ram_we),   32'h0);
    tick();
    bus.vid_req = 1'b0;
    mid();
    check("v1_data_n1", 32'(bus.vid_data), 32'h00);
    check("v1_ram_we1", 32'(bus.ram_we),   32'h0);
    tick();
    mid();
    check("v1_data_n2", 32'(bus.vid_data), 32'h5A);
    check("v1_ram_we2", 32'(bus.ram_we),   32'h0);

    // 2: CPU write 0x1FFF<=0xC3, then read it back
    tick();
    cpu_drive(1'b1, 1'b1, 13'h1FFF, 8'hC3);
    mid();
`ifdef VRAM_WBUF_EN
    check("w2_posted_no_we", 32'(bus.ram_we), 32'h0);
`else
    check("w2_ram_we",    32'(bus.ram_we),    32'h1);
    check("w2_ram_addr",  32'(bus.ram_addr),  32'h1FFF);
    check("w2_ram_wdata", 32'(bus.ram_wdata), 32'hC3);
`endif
    check("w2_ack_n0", 32'(bus.cpu_ack), 32'h0);
    tick();
    mid();
    check("w2_ack_n1", 32'(bus.cpu_ack), 32'h1);
`ifdef VRAM_WBUF_EN
    check("w2_drain_we",    32'(bus.ram_we),    32'h1);
    check("w2_drain_addr",  32'(bus.ram_addr),  32'h1FFF);
    check("w2_drain_wdata", 32'(bus.ram_wdata), 32'hC3);
`else
    check("w2_ram_we_off", 32'(bus.ram_we), 32'h0);
`endif
    tick();
    cpu_drive(1'b0, 1'b0, 13'h0000, 8'h00);
    mid();
    check("w2_ack_gone", 32'(bus.cpu_ack), 32'h0);
    tick();
    cpu_drive(1'b1, 1'b0, 13'h1FFF, 8'h00);
    mid();
    check("r2_ram_addr", 32'(bus.ram_addr), 32'h1FFF);
    check("r2_ram_we",   32'(bus.ram_we),   32'h0);
    tick();
    mid();
    check("r2_ack_n1", 32'(bus.cpu_ack), 32'h0);
    tick();
    mid();
    check("r2_ack_n2", 32'(bus.cpu_ack),   32'h1);
    check("r2_rdata",  32'(bus.cpu_rdata), 32'hC3);
    tick();
    cpu_drive(1'b0, 1'b0, 13'h0000, 8'h00);
    mid();
    check("r2_ack_gone", 32'(bus.cpu_ack), 32'h0);

    // 3: CPU read and video fetch collide; video first, CPU one cycle later
    tick();
    cpu_drive(1'b1, 1'b0, 13'h0123, 8'h00);
    bus.vid_req  = 1'b1;
    bus.vid_addr = 13'h1FFF;
    mid();
    check("c3_vid_wins", 32'(bus.ram_addr),  32'h1FFF);
    check("c3_state_n0", 32'(bus.dbg_state), 32'(C_IDLE));
    tick();
    bus.vid_req = 1'b0;
    mid();
    check("c3_cpu_next", 32'(bus.ram_addr), 32'h0123);
    check("c3_ack_n1",   32'(bus.cpu_ack),  32'h0);
    tick();
    mid();
    check("c3_vid_data", 32'(bus.vid_data),  32'hC3);
    check("c3_state_n2", 32'(bus.dbg_state), 32'(C_RD));
    check("c3_ack_n2",   32'(bus.cpu_ack),   32'h0);
    tick();
    mid();
    check("c3_ack_n3", 32'(bus.cpu_ack),   32'h1);
    check("c3_rdata",  32'(bus.cpu_rdata), 32'h5A);
    tick();
    cpu_drive(1'b0, 1'b0, 13'h0000, 8'h00);

    // 4: video every cycle for 6 cycles against a pending CPU read;
    //    the CPU is refused 4 times and wins the 5th cycle
    cpu_drive(1'b1, 1'b0, 13'h1FFF, 8'h00);
    bus.vid_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.vid_addr = 13'h0100 + 13'(i);
      mid();
      if (i == 4) begin
        check("s4_cpu_override", 32'(bus.ram_addr), 32'h1FFF);
      end else begin
        check("s4_vid_addr", 32'(bus.ram_addr), 32'h0100 + 32'(i));
      end
      check("s4_vid_miss", 32'(bus.vid_miss), (i >= 5) ? 32'h1 : 32'h0);
      if (i == 2) begin
        check("s4_vid_data_f0", 32'(bus.vid_data), 32'h10);
      end
      if (i == 5) begin
        check("s4_vid_data_f3", 32'(bus.vid_data),  32'h13);
        check("s4_state_rd",    32'(bus.dbg_state), 32'(C_RD));
      end
      tick();
    end
    bus.vid_req = 1'b0;
    mid();
    check("s4_ack",          32'(bus.cpu_ack),   32'h1);
    check("s4_rdata",        32'(bus.cpu_rdata), 32'hC3);
    check("s4_vid_data_skip",32'(bus.vid_data),  32'h13);
    tick();
    cpu_drive(1'b0, 1'b0, 13'h0000, 8'h00);
    mid();
    check("s4_vid_data_f5", 32'(bus.vid_data), 32'h15);
    check("s4_miss_sticky", 32'(bus.vid_miss), 32'h1);
    check("s4_ack_gone",    32'(bus.cpu_ack),  32'h0);

    // 5: reset in the middle of a read aborts it without an ack
    tick();
    cpu_drive(1'b1, 1'b0, 13'h0100, 8'h00);
    mid();
    check("r5_ram_addr", 32'(bus.ram_addr), 32'h0100);
    tick();
    mid();
    check("r5_state_rd", 32'(bus.dbg_state), 32'(C_RD));
    reset = 1'b1;
    cpu_drive(1'b0, 1'b0, 13'h0000, 8'h00);
    #1;
    check("r5_ack",      32'(bus.cpu_ack),   32'h0);
    check("r5_state",    32'(bus.dbg_state), 32'(C_IDLE));
    check("r5_vid_data", 32'(bus.vid_data),  32'h00);
    check("r5_vid_miss", 32'(bus.vid_miss),  32'h0);
    check("r5_rdata",    32'(bus.cpu_rdata), 32'h00);
    check("r5_ram_we",   32'(bus.ram_we),    32'h0);
    check("r5_ram_addr", 32'(bus.ram_addr),  32'h0000);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mid();
      check("r5_no_ack_after", 32'(bus.cpu_ack), 32'h0);
      tick();
    end
    cpu_drive(1'b1, 1'b0, 13'h0101, 8'h00);
    mid();
    check("r5b_ram_addr", 32'(bus.ram_addr), 32'h0101);
    tick();
    mid();
    check("r5b_ack_n1", 32'(bus.cpu_ack), 32'h0);
    tick();
    mid();
    check("r5b_ack_n2", 32'(bus.cpu_ack),   32'h1);
    check("r5b_rdata",  32'(bus.cpu_rdata), 32'h11);
    tick();
    cpu_drive(1'b0, 1'b0, 13'h0000, 8'h00);

`ifdef VRAM_WBUF_EN
    // 6: posted write + forwarded read under continuous video, drain after
    bus.vid_req  = 1'b1;
    bus.vid_addr = 13'h0100;
    cpu_drive(1'b1, 1'b1, 13'h0040, 8'h11);
    mid();
    check("b6_no_we_w",   32'(bus.ram_we),   32'h0);
    check("b6_vid_addr",  32'(bus.ram_addr), 32'h0100);
    check("b6_ack_w_n0",  32'(bus.cpu_ack),  32'h0);
    tick();
    mid();
    check("b6_ack_w_n1",  32'(bus.cpu_ack),  32'h1);
    check("b6_no_we_a",   32'(bus.ram_we),   32'h0);
    tick();
    cpu_drive(1'b1, 1'b0, 13'h0040, 8'h00);
    mid();
    check("b6_rd_vid",    32'(bus.ram_addr), 32'h0100);
    check("b6_rd_no_we",  32'(bus.ram_we),   32'h0);
    check("b6_ack_r_n0",  32'(bus.cpu_ack),  32'h0);
    tick();
    mid();
    check("b6_ack_r_n1",  32'(bus.cpu_ack),   32'h1);
    check("b6_fwd_rdata", 32'(bus.cpu_rdata), 32'h11);
    check("b6_held",      32'(bus.ram_we),    32'h0);
    tick();
    cpu_drive(1'b0, 1'b0, 13'h0000, 8'h00);
    bus.vid_req = 1'b0;
    mid();
    check("b6_drain_we",    32'(bus.ram_we),    32'h1);
    check("b6_drain_addr",  32'(bus.ram_addr),  32'h0040);
    check("b6_drain_wdata", 32'(bus.ram_wdata), 32'h11);
    tick();
    mid();
    check("b6_drain_once", 32'(bus.ram_we), 32'h0);
`endif

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
